// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host state encoding, command/response byte codes and parity helper
package ps2_pkg;

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, TX, WAIT_RESP} ps2_state_t;

    localparam logic [7:0] PS2_ACK         = 8'hFA;
    localparam logic [7:0] PS2_RESEND      = 8'hFE;
    localparam logic [7:0] PS2_BAT_OK      = 8'hAA;
    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizers for the PS/2 clock/data pads plus a falling-edge strobe on the clock
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic clk_pad,
    input  logic data_pad,
    output logic data_s,
    output logic clk_fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // synchronize both pads; reset to the idle-high bus level so no edge appears out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], clk_pad};
            data_ff  <= {data_ff[0], data_pad};
            clk_prev <= clk_ff[1];
        end
    end

    assign data_s   = data_ff[1];
    assign clk_fall = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_cmd_controller.sv
// ps2_host_cmd_controller: PS/2 host-to-device command sequencer (inhibit, RTS, frame, line ACK, 0xFA/0xFE response, retries); PS2_TX_WATCHDOG_EN adds a per-bit TX watchdog
module ps2_host_cmd_controller
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RESP_TIMEOUT   = 1000000,
    parameter int MAX_RETRIES    = 3,
    parameter int BIT_TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_has_arg,
    input  logic [7:0] arg_byte,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_drive_low,
    output logic       ps2data_drive_low,
    output logic       rx_inhibit,
    output logic       done,
    output logic       error,
    output logic       busy
);

    localparam int CMAX = (INHIBIT_CYCLES > RESP_TIMEOUT) ?
                          ((INHIBIT_CYCLES > BIT_TIMEOUT) ? INHIBIT_CYCLES : BIT_TIMEOUT) :
                          ((RESP_TIMEOUT > BIT_TIMEOUT) ? RESP_TIMEOUT : BIT_TIMEOUT);
    localparam int CW = $clog2(CMAX + 1);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [CW-1:0] CNT_SAT  = CW'(CMAX);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] RESP_TO  = CW'(RESP_TIMEOUT);
    localparam logic [RW-1:0] RETRY_MX = RW'(MAX_RETRIES);
`ifdef PS2_TX_WATCHDOG_EN
    localparam logic [CW-1:0] BIT_TO   = CW'(BIT_TIMEOUT);
`endif

    ps2_state_t    state;
    logic [7:0]    cmd_q, arg_q;
    logic          has_arg_q, sel;
    logic [RW-1:0] retry;
    logic [CW-1:0] cnt, cnt_inc;
    logic [3:0]    bitk;
    logic          data_s, clk_fall;
    logic [7:0]    tx_byte;
    logic          tx_level;

    ps2_line_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .clk_pad (ps2clk_in),
        .data_pad(ps2data_in),
        .data_s  (data_s),
        .clk_fall(clk_fall)
    );

    assign tx_byte  = sel ? arg_q : cmd_q;
    assign tx_level = (bitk < 4'd8) ? ~tx_byte[bitk[2:0]] : (bitk == 4'd8) ? ~odd_parity(tx_byte) : 1'b0;
    assign cnt_inc  = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

    // command sequencer; every output is registered and moves together with the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            cmd_q             <= 8'h00;
            arg_q             <= 8'h00;
            has_arg_q         <= 1'b0;
            sel               <= 1'b0;
            retry             <= '0;
            cnt               <= '0;
            bitk              <= 4'd0;
            cmd_ready         <= 1'b1;
            busy              <= 1'b0;
            ps2clk_drive_low  <= 1'b0;
            ps2data_drive_low <= 1'b0;
            rx_inhibit        <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    cmd_q            <= cmd_byte;
                    arg_q            <= arg_byte;
                    has_arg_q        <= cmd_has_arg;
                    sel              <= 1'b0;
                    retry            <= '0;
                    cnt              <= '0;
                    cmd_ready        <= 1'b0;
                    busy             <= 1'b1;
                    ps2clk_drive_low <= 1'b1;
                    rx_inhibit       <= 1'b1;
                    state            <= INHIBIT;
                end
                INHIBIT: if (cnt == INH_LAST) begin
                    ps2clk_drive_low  <= 1'b0;
                    ps2data_drive_low <= 1'b1;
                    state             <= RTS;
                end else begin
                    cnt <= cnt_inc;
                end
                RTS: begin
                    cnt   <= '0;
                    bitk  <= 4'd0;
                    state <= TX;
                end
                TX: if (clk_fall) begin
                    cnt  <= '0;
                    bitk <= bitk + 4'd1;
                    if (bitk != 4'd10) begin
                        ps2data_drive_low <= tx_level;
                    end else if (!data_s) begin
                        rx_inhibit <= 1'b0;
                        state      <= WAIT_RESP;
                    end else begin
                        error             <= 1'b1;
                        ps2data_drive_low <= 1'b0;
                        rx_inhibit        <= 1'b0;
                        cmd_ready         <= 1'b1;
                        busy              <= 1'b0;
                        state             <= IDLE;
                    end
                end
`ifdef PS2_TX_WATCHDOG_EN
                else if (cnt == BIT_TO) begin
                    error             <= 1'b1;
                    ps2clk_drive_low  <= 1'b0;
                    ps2data_drive_low <= 1'b0;
                    rx_inhibit        <= 1'b0;
                    cmd_ready         <= 1'b1;
                    busy              <= 1'b0;
                    state             <= IDLE;
                end else begin
                    cnt <= cnt_inc;
                end
`endif
                WAIT_RESP: if (rx_valid && rx_byte == PS2_ACK) begin
                    if (!sel && has_arg_q) begin
                        sel              <= 1'b1;
                        retry            <= '0;
                        cnt              <= '0;
                        ps2clk_drive_low <= 1'b1;
                        rx_inhibit       <= 1'b1;
                        state            <= INHIBIT;
                    end else begin
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end else if ((rx_valid && rx_byte == PS2_RESEND) || cnt == RESP_TO) begin
                    if (retry < RETRY_MX) begin
                        retry            <= retry + 1'b1;
                        cnt              <= '0;
                        ps2clk_drive_low <= 1'b1;
                        rx_inhibit       <= 1'b1;
                        state            <= INHIBIT;
                    end else begin
                        error     <= 1'b1;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end else begin
                    cnt <= cnt_inc;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_cmd_controller.sv
// tb_ps2_host_cmd_controller: device model, response model and cycle compare for the PS/2 command sequencer
module tb_ps2_host_cmd_controller;

    localparam int INH = 40, RTO = 200, MR = 3, BTO = 500, HALF = 8;
    localparam int B_ACK = 0, B_RES = 1, B_TO = 2, B_NACK = 3;

    logic       clk = 1'b0, rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_has_arg = 1'b0, rx_valid = 1'b0;
    logic [7:0] cmd_byte = 8'h00, arg_byte = 8'h00, rx_byte = 8'h00;
    logic       cmd_ready, ps2clk_in, ps2data_in, ps2clk_drive_low, ps2data_drive_low;
    logic       rx_inhibit, done, error, busy;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
    int         checks = 0, errors = 0, inh = 0, nframes = 0, last_pulse = 0;
    int         plan[$];
    int         expq[$];
    logic [8:0] seen[$];
    logic [7:0] fd;
    logic       fp, fst;

    ps2_host_cmd_controller #(
        .INHIBIT_CYCLES(INH), .RESP_TIMEOUT(RTO), .MAX_RETRIES(MR), .BIT_TIMEOUT(BTO)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_byte(cmd_byte), .cmd_has_arg(cmd_has_arg), .arg_byte(arg_byte),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .ps2clk_in(ps2clk_in), .ps2data_in(ps2data_in),
        .ps2clk_drive_low(ps2clk_drive_low), .ps2data_drive_low(ps2data_drive_low),
        .rx_inhibit(rx_inhibit), .done(done), .error(error), .busy(busy)
    );

    assign ps2clk_in  = ~(ps2clk_drive_low | dev_clk_low);
    assign ps2data_in = ~(ps2data_drive_low | dev_data_low);

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        int r = $urandom_range(0, 9);
        return (r < 6) ? B_ACK : (r < 8) ? B_RES : (r == 8) ? B_TO : B_NACK;
    endfunction

    function automatic logic [7:0] noise();
        logic [7:0] b = 8'($urandom);
        return (b == 8'hFA || b == 8'hFE) ? 8'h00 : b;
    endfunction

    // every cycle: pulses against the expected-outcome queue, invariants, inhibit length
    always @(negedge clk) begin
        if (rst) inh = 0;
        else begin
            chk("done_error_excl", done & error, 0);
            chk("ready_vs_busy", cmd_ready, !busy);
            if (done || error) begin
                if (expq.size() == 0) chk("unexpected_pulse", {done, error}, 0);
                else chk("outcome", done ? 1 : 2, expq.pop_front());
                last_pulse = done ? 1 : 2;
            end
            if (ps2clk_drive_low) inh++;
            else if (inh != 0) begin
                chk("inhibit_len", inh, INH);
                inh = 0;
            end
        end
    end

    task automatic dev_frame(input logic ack, input int abort_at);
        int n = 0;
        fd = 8'h00; fp = 1'b0; fst = 1'b0;
        while (!(ps2data_drive_low && !ps2clk_drive_low) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("rts_seen", n < 1000, 1);
        chk("rx_inhibit_tx", rx_inhibit, 1);
        repeat (4) @(negedge clk);
        for (int i = 1; i <= 11 && i < abort_at; i++) begin
            if (i == 11) begin
                dev_data_low = ack;
                repeat (4) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i <= 8) fd[i-1] = !ps2data_drive_low;
            else if (i == 9) fp = !ps2data_drive_low;
            else if (i == 10) fst = !ps2data_drive_low;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        dev_data_low = 1'b0;
        nframes++;
        seen.push_back({fp, fd});
    endtask

    task automatic send_rx(input logic [7:0] b);
        repeat ($urandom_range(1, 6)) @(negedge clk);
        rx_byte = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte = 8'($urandom);
    endtask

    task automatic handshake(input logic [7:0] c, input logic ha, input logic [7:0] a);
        nframes = 0;
        seen.delete();
        @(negedge clk);
        chk("ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_byte = c; cmd_has_arg = ha; arg_byte = a;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_byte = 8'($urandom); arg_byte = 8'($urandom); cmd_has_arg = 1'($urandom);
        chk("busy_after_hs", busy, 1);
    endtask

    task automatic run_cmd(input logic [7:0] c, input logic ha, input logic [7:0] a);
        logic       second = 1'b0;
        bit         fin = 1'b0;
        int         tries = 0, beh, n = 0;
        logic [7:0] want;
        handshake(c, ha, a);
        repeat (5) @(negedge clk);
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        while (!fin) begin
            want = second ? a : c;
            beh = (plan.size() != 0) ? plan.pop_front() : pick();
            if (beh == B_NACK) begin
                expq.push_back(2);
                fin = 1'b1;
            end
            dev_frame(beh != B_NACK, 12);
            chk("frame_byte", fd, want);
            chk("frame_parity", fp, ~^want);
            chk("frame_stop", fst, 1);
            if (beh != B_NACK) begin
                repeat (2) @(negedge clk);
                chk("rx_inhibit_wait", rx_inhibit, 0);
                if ($urandom_range(0, 3) == 0) send_rx(noise());
                if (beh == B_ACK) begin
                    if (!second && ha) begin
                        second = 1'b1;
                        tries = 0;
                    end else begin
                        expq.push_back(1);
                        fin = 1'b1;
                    end
                    send_rx(8'hFA);
                end else begin
                    if (tries < MR) tries++;
                    else begin
                        expq.push_back(2);
                        fin = 1'b1;
                    end
                    if (beh == B_RES) send_rx(8'hFE);
                end
            end
        end
        while (expq.size() != 0 && n < RTO + 100) begin
            @(negedge clk);
            n++;
        end
        chk("outcome_pending", expq.size(), 0);
        expq.delete();
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_pads", {ps2clk_drive_low, ps2data_drive_low}, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_outs", {busy, ps2clk_drive_low, ps2data_drive_low, rx_inhibit, done, error}, 0);
        rst = 1'b0;

        plan = '{B_ACK};
        run_cmd(8'hF4, 1'b0, 8'h00);
        chk("f4_frames", nframes, 1);
        chk("f4_frame", seen[0], 9'h0F4);
        chk("f4_pulse", last_pulse, 1);

        plan = '{B_ACK, B_ACK};
        run_cmd(8'hED, 1'b1, 8'h07);
        chk("led_frames", nframes, 2);
        chk("led_frame0", seen[0], 9'h1ED);
        chk("led_frame1", seen[1], 9'h007);
        chk("led_pulse", last_pulse, 1);

        plan = '{B_RES, B_RES, B_ACK};
        run_cmd(8'hFF, 1'b0, 8'h00);
        chk("resend_frames", nframes, 3);
        chk("resend_frame2", seen[2], 9'h1FF);
        chk("resend_pulse", last_pulse, 1);

        plan = '{B_TO, B_TO, B_TO, B_TO};
        run_cmd(8'hF4, 1'b0, 8'h00);
        chk("timeout_frames", nframes, 4);
        chk("timeout_pulse", last_pulse, 2);

        last_pulse = 0;
        plan = '{B_NACK};
        run_cmd(8'hEE, 1'b0, 8'h00);
        chk("nack_frames", nframes, 1);
        chk("nack_pulse", last_pulse, 2);

        handshake(8'h00, 1'b0, 8'h00);
        dev_frame(1'b1, 5);
        chk("pre_rst_data", ps2data_drive_low, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_pads", {ps2clk_drive_low, ps2data_drive_low}, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_busy", {busy, rx_inhibit}, 0);
        @(negedge clk);
        rst = 1'b0;

`ifdef PS2_TX_WATCHDOG_EN
        begin
            int n = 0;
            handshake(8'h55, 1'b0, 8'h00);
            expq.push_back(2);
            dev_frame(1'b1, 4);
            while (expq.size() != 0 && n < BTO + 100) begin
                @(negedge clk);
                n++;
            end
            chk("wdog_pending", expq.size(), 0);
            expq.delete();
            @(negedge clk);
            chk("wdog_idle", {busy, ps2clk_drive_low, ps2data_drive_low}, 0);
        end
`endif

        repeat (12) run_cmd(8'($urandom), 1'($urandom), 8'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
